// File: rtl/cdb_lane_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdb_lane_arbiter                                           |
// | Description : Merges several functional-unit result ports onto one CDB   |
// |               lane. Each source owns a small FIFO; a round-robin arbiter |
// |               pops one head per cycle into registered lane outputs.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// ROB index width normally comes from the project-wide defines; keep a sane
// fallback so the block elaborates stand-alone.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module cdb_lane_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 4,
   parameter int ROB_W   = `ROB_ENTRY_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [NUM_SRC-1:0]       src_ready,
   input  logic [NUM_SRC*ROB_W-1:0] src_rob_index,
   input  logic [NUM_SRC*32-1:0]    src_data,
   output logic [ROB_W-1:0]         CDB_ROB_index,
   output logic [31:0]              CDB_data,
   output logic                     busy
);

   localparam int C_AW  = $clog2(DEPTH);
   localparam int C_CW  = C_AW + 1;
   localparam int C_SW  = $clog2(NUM_SRC);
   localparam int C_SW1 = C_SW + 1;
   localparam logic [C_CW-1:0]  C_FULL    = C_CW'(DEPTH);
   localparam logic [C_SW-1:0]  C_LAST    = C_SW'(NUM_SRC - 1);
   localparam logic [C_SW1-1:0] C_NUM_SRC = C_SW1'(NUM_SRC);

   logic [NUM_SRC-1:0] w_nonempty;
   logic [NUM_SRC-1:0] w_push;
   logic [NUM_SRC-1:0] w_pop;
   logic [ROB_W-1:0]   w_head_tag  [NUM_SRC];
   logic [31:0]        w_head_data [NUM_SRC];

   logic [C_SW-1:0]    r_rr_ptr;
   logic [C_SW-1:0]    w_winner;
   logic [C_SW-1:0]    w_rr_next;
   logic [C_SW-1:0]    w_idx;
   logic [C_SW1-1:0]   w_sum;
   logic               w_found;

   // ------------------------------------------------------------------
   // Per-source result FIFOs
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [ROB_W-1:0] r_mem_tag  [DEPTH];
         logic [31:0]      r_mem_data [DEPTH];
         logic [C_AW-1:0]  r_wr_ptr;
         logic [C_AW-1:0]  r_rd_ptr;
         logic [C_CW-1:0]  r_count;
         logic [ROB_W-1:0] w_tag_in;
         logic [31:0]      w_data_in;

         assign w_tag_in  = src_rob_index[gi*ROB_W +: ROB_W];
         assign w_data_in = src_data[gi*32 +: 32];

         // Ready looks only at occupancy: a full FIFO stays not-ready even
         // while its head is being popped, keeping the path short.
         assign src_ready[gi]  = (r_count != C_FULL);
         assign w_nonempty[gi] = (r_count != '0);
         // Tag 0 means "no broadcast" downstream, so it is never buffered.
         assign w_push[gi] = src_valid[gi] & src_ready[gi] & (w_tag_in != '0);
         assign w_pop[gi]  = w_found & (w_winner == C_SW'(gi));

         assign w_head_tag[gi]  = r_mem_tag[r_rd_ptr];
         assign w_head_data[gi] = r_mem_data[r_rd_ptr];

         // Entry storage; contents are don't-care until counted, so no reset.
         always_ff @(posedge clk) begin
            if (w_push[gi] && !flush) begin
               r_mem_tag[r_wr_ptr]  <= w_tag_in;
               r_mem_data[r_wr_ptr] <= w_data_in;
            end
         end

         // Pointers and occupancy; flush overrides any same-cycle push/pop.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else if (flush) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
               if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
               case ({w_push[gi], w_pop[gi]})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   endgenerate

   // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_sum = {1'b0, r_rr_ptr} + C_SW1'(k);
         if (w_sum >= C_NUM_SRC) w_sum = w_sum - C_NUM_SRC;
         w_idx = w_sum[C_SW-1:0];
         if (!w_found && w_nonempty[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Pointer advances to the slot just past the winner, modulo NUM_SRC.
   always_comb begin
      w_rr_next = (w_winner == C_LAST) ? '0 : w_winner + 1'b1;
   end

   // Lane output registers: one popped head per cycle, 0/0 when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CDB_ROB_index <= '0;
         CDB_data      <= '0;
         r_rr_ptr      <= '0;
      end else if (flush) begin
         CDB_ROB_index <= '0;
         CDB_data      <= '0;
         r_rr_ptr      <= '0;
      end else if (w_found) begin
         CDB_ROB_index <= w_head_tag[w_winner];
         CDB_data      <= w_head_data[w_winner];
         r_rr_ptr      <= w_rr_next;
      end else begin
         CDB_ROB_index <= '0;
         CDB_data      <= '0;
      end
   end

   assign busy = |w_nonempty;

endmodule

`default_nettype wire

// File: tb/tb_cdb_lane_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cdb_lane_arbiter                                        |
// | Description : Directed bench for cdb_lane_arbiter with a queue-based     |
// |               scoreboard of expected broadcasts (tag, data, cycle).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cdb_lane_arbiter;

   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 4;
   localparam int ROB_W   = 6;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     flush;
   logic [NUM_SRC-1:0]       src_valid;
   logic [NUM_SRC-1:0]       src_ready;
   logic [NUM_SRC*ROB_W-1:0] src_rob_index;
   logic [NUM_SRC*32-1:0]    src_data;
   logic [ROB_W-1:0]         CDB_ROB_index;
   logic [31:0]              CDB_data;
   logic                     busy;

   typedef struct {
      logic [ROB_W-1:0] tag;
      logic [31:0]      data;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   cdb_lane_arbiter #(
      .NUM_SRC(NUM_SRC),
      .DEPTH  (DEPTH),
      .ROB_W  (ROB_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_rob_index(src_rob_index),
      .src_data     (src_data),
      .CDB_ROB_index(CDB_ROB_index),
      .CDB_data     (CDB_data),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Edge counter: at the negedge after rising edge K it reads K.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] d0f(input int t);
      return 32'hA000_0000 | 32'(t);
   endfunction

   function automatic logic [31:0] d1f(input int t);
      return 32'hB000_0000 | 32'(t);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input int t0, input logic [31:0] dd0,
                        input logic v1, input int t1, input logic [31:0] dd1);
      src_valid     = {v1, v0};
      src_rob_index = {ROB_W'(t1), ROB_W'(t0)};
      src_data      = {dd1, dd0};
   endtask

   task automatic idle();
      drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
   endtask

   task automatic expect_b(input int t, input logic [31:0] d, input int c);
      exp_t e;
      e.tag  = ROB_W'(t);
      e.data = d;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Scoreboard monitor: every non-zero broadcast must match the queue head
   // in tag, data and cycle; idle cycles must show zero data.
   always @(negedge clk) begin
      if (CDB_ROB_index != '0) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bcast: got tag=%0d data=%h cyc=%0d want none",
                     CDB_ROB_index, CDB_data, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (CDB_ROB_index !== mon_e.tag || CDB_data !== mon_e.data || cyc != mon_e.cyc) begin
               failures++;
               $display("FAIL bcast: got tag=%0d data=%h cyc=%0d want tag=%0d data=%h cyc=%0d",
                        CDB_ROB_index, CDB_data, cyc, mon_e.tag, mon_e.data, mon_e.cyc);
            end
         end
      end else begin
         checks++;
         if (CDB_data !== 32'h0) begin
            failures++;
            $display("FAIL idle_data: got %h want 0 cyc=%0d", CDB_data, cyc);
         end
         if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            checks++;
            failures++;
            mon_e = sb.pop_front();
            $display("FAIL missing_bcast: got idle cyc=%0d want tag=%0d cyc=%0d",
                     cyc, mon_e.tag, mon_e.cyc);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout want completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int i0;
      int i1;
      int e;
      logic [NUM_SRC-1:0] rdy;
      int t4_tags [16] = '{1, 20, 2, 21, 3, 22, 4, 23, 5, 24, 6, 25, 7, 26, 8, 27};

      // Reset state
      rst_n = 1'b0;
      flush = 1'b0;
      idle();
      tick();
      tick();
      chk("reset_ready", 64'(src_ready), 64'h3);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_tag", 64'(CDB_ROB_index), 64'h0);
      chk("reset_data", 64'(CDB_data), 64'h0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Single push on src0: visible exactly one cycle after the push edge
      n = cyc + 1;
      expect_b(5, 32'hDEADBEEF, n + 1);
      drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
      tick();
      idle();
      chk("single_busy_after_push", 64'(busy), 64'h1);
      tick();
      chk("single_busy_after_pop", 64'(busy), 64'h0);
      repeat (3) tick();

      // Single push on src1 (also steers rr_ptr back to 0)
      n = cyc + 1;
      expect_b(33, d1f(33), n + 1);
      drive(1'b0, 0, 32'h0, 1'b1, 33, d1f(33));
      tick();
      idle();
      repeat (3) tick();

      // Contention: strict alternation 1,9,2,10,3,11
      n = cyc + 1;
      expect_b(1,  d0f(1),  n + 1);
      expect_b(9,  d1f(9),  n + 2);
      expect_b(2,  d0f(2),  n + 3);
      expect_b(10, d1f(10), n + 4);
      expect_b(3,  d0f(3),  n + 5);
      expect_b(11, d1f(11), n + 6);
      drive(1'b1, 1, d0f(1), 1'b1, 9,  d1f(9));
      tick();
      drive(1'b1, 2, d0f(2), 1'b1, 10, d1f(10));
      tick();
      drive(1'b1, 3, d0f(3), 1'b1, 11, d1f(11));
      tick();
      idle();
      repeat (6) tick();

      // Both sources streaming until their FIFOs fill and backpressure
      n = cyc + 1;
      for (int k = 0; k < 16; k++) begin
         expect_b(t4_tags[k], (t4_tags[k] < 20) ? d0f(t4_tags[k]) : d1f(t4_tags[k]), n + 1 + k);
      end
      i0 = 0;
      i1 = 0;
      for (int step = 0; step < 40 && (i0 < 8 || i1 < 8); step++) begin
         drive(i0 < 8, i0 + 1, d0f(i0 + 1), i1 < 8, 20 + i1, d1f(20 + i1));
         rdy = src_ready;
         e   = cyc + 1;
         tick();
         if (i0 < 8 && rdy[0]) i0++;
         if (i1 < 8 && rdy[1]) i1++;
         if (e == n + 6) chk("full_src0_ready", 64'(src_ready), 64'h2);
         if (e == n + 7) chk("full_src1_ready", 64'(src_ready), 64'h1);
      end
      chk("stream_all_accepted", 64'((i0 == 8) && (i1 == 8)), 64'h1);
      idle();
      repeat (18) tick();

      // Tag-0 valid is dropped
      drive(1'b1, 0, 32'h1234, 1'b0, 0, 32'h0);
      tick();
      idle();
      chk("tag0_busy", 64'(busy), 64'h0);
      chk("tag0_ready", 64'(src_ready), 64'h3);
      repeat (3) tick();

      // Flush with buffered results and a concurrent push of tag 7
      n = cyc + 1;
      expect_b(40, d0f(40), n + 1);
      drive(1'b1, 40, d0f(40), 1'b1, 50, d1f(50));
      tick();
      drive(1'b1, 41, d0f(41), 1'b1, 51, d1f(51));
      tick();
      chk("preflush_busy", 64'(busy), 64'h1);
      flush = 1'b1;
      drive(1'b1, 7, d0f(7), 1'b0, 0, 32'h0);
      tick();
      flush = 1'b0;
      idle();
      chk("flush_busy", 64'(busy), 64'h0);
      chk("flush_tag", 64'(CDB_ROB_index), 64'h0);
      chk("flush_data", 64'(CDB_data), 64'h0);
      chk("flush_ready", 64'(src_ready), 64'h3);
      repeat (3) tick();
      n = cyc + 1;
      expect_b(13, d0f(13), n + 1);
      expect_b(14, d1f(14), n + 2);
      drive(1'b1, 13, d0f(13), 1'b1, 14, d1f(14));
      tick();
      idle();
      repeat (4) tick();

      // Asynchronous reset mid-broadcast discards the buffered tail
      n = cyc + 1;
      expect_b(60, d0f(60), n + 1);
      drive(1'b1, 60, d0f(60), 1'b0, 0, 32'h0);
      tick();
      drive(1'b1, 61, d0f(61), 1'b0, 0, 32'h0);
      tick();
      idle();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tag", 64'(CDB_ROB_index), 64'h0);
      chk("async_rst_data", 64'(CDB_data), 64'h0);
      chk("async_rst_busy", 64'(busy), 64'h0);
      chk("async_rst_ready", 64'(src_ready), 64'h3);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();

      chk("scoreboard_drained", 64'(sb.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
